demux8_stream: RTL and testbench
================================

// Module: demux8_stream
// PURPOSE
//   1-to-2 byte demultiplexer with valid/ready handshake; the splitting counterpart of the 8-bit 2:1 mux.
//   Accepts one byte per cycle with a select bit and routes it to output 0 or output 1.
//   Buffers each output in its own small FIFO, so a stalled consumer never blocks the other output.
//   Keeps per-output byte counters.
// PARAMETERS
//   WIDTH  8  data width in bits
//   DEPTH  2  entries per output FIFO; power of two, >= 2
//   CNT_W  8  width of per-output accepted-byte counters
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   clr       in   1      synchronous clear of both FIFOs and both counters
//   in_data   in   WIDTH  input byte
//   in_sel    in   1      0 -> route to y0, 1 -> route to y1
//   in_valid  in   1      in_data/in_sel valid
//   in_ready  out  1      block accepts this cycle
//   y0_data   out  WIDTH  head of FIFO 0
//   y0_valid  out  1      FIFO 0 non-empty
//   y0_ready  in   1      consumer 0 takes y0_data
//   y1_data   out  WIDTH  head of FIFO 1
//   y1_valid  out  1      FIFO 1 non-empty
//   y1_ready  in   1      consumer 1 takes y1_data
//   cnt0      out  CNT_W  bytes accepted for y0
//   cnt1      out  CNT_W  bytes accepted for y1
// BEHAVIOUR
//   - Clocking and reset: one clock. Reset is asynchronous, active-low.
//   - Reset values:
//     - FIFOs empty; y0/y1_valid = 0; y0/y1_data = 0.
//     - cnt0 = cnt1 = 0; run flag = 0.
//     - in_ready = 0 while rst_n is low and on the first clk edge after release.
//   - Run flag: set to 1 on the first clk edge after rst_n deasserts; stays 1 until the next reset.
//   - in_ready = run & ~clr & ~full[in_sel]; combinational on in_sel.
//     - Depends only on the FIFO count; a same-cycle pop does not free a slot.
//   - Accept: in_valid & in_ready. The byte is pushed into FIFO[in_sel].
//     - The matching counter increments, wrapping 2^CNT_W-1 -> 0.
//   - Latency: a byte accepted at edge N appears on yX_data with yX_valid = 1 after edge N (1 cycle).
//     - No combinational in->out path.
//   - Pop: yX_valid & yX_ready at an edge removes the head entry.
//     - yX_data and yX_valid are held stable while valid & ~ready.
//   - Push and pop on the same FIFO in one cycle: count unchanged, order preserved.
//     - When count = 1, the new byte becomes the head on the next cycle.
//   - The two outputs are fully independent. Order within each output equals acceptance order.
//   - Full FIFO: in_ready = 0 for that select only. Bytes for the other output still flow.
//   - in_valid = 0: in_sel and in_data are ignored; no state change.
//   - clr = 1 at an edge:
//     - Empties both FIFOs and zeroes both counters.
//     - Overrides any push or pop that cycle; in_ready = 0 during clr.
//   - Reset mid-operation: all buffered bytes are discarded; valids drop immediately (asynchronously).
//   - Overflow or underflow is impossible by construction.
//     - The bench flags any write to a full FIFO or read of an empty FIFO as an error.
// STRUCTURE
//   - demux8_pkg:
//     - SEL_Y0 = 1'b0, SEL_Y1 = 1'b1.
//     - Default WIDTH / DEPTH / CNT_W localparams.
//   - Sub-module sync_fifo (WIDTH, DEPTH), instantiated twice.
//     - Ports: clk, rst_n, clr, push, din, pop, dout, empty, full.
//     - Pointer-based, count of log2(DEPTH)+1 bits, registered head.
//   - Top: run flag, in_ready/push decode, two counters, two FIFO instances.
// TESTING
//   1. Reset then idle: rst_n low 3 cycles, then high.
//      -> all outputs 0; in_ready = 0 on the first edge after release, 1 from the second.
//   2. Route: send 0xA5 sel=0, then 0x3C sel=1, y0/y1_ready = 1.
//      -> y0 = 0xA5 one cycle after its accept, y1 = 0x3C one cycle after its accept.
//      -> cnt0 = 1, cnt1 = 1.
//   3. Backpressure: y0_ready = 0, push 0x11, 0x22, 0x33 to sel=0 (DEPTH=2).
//      -> in_ready drops after 2 accepts; y0_data holds 0x11.
//      -> meanwhile 0x77 sel=1 is still accepted.
//      -> on releasing y0_ready: 0x11, 0x22, 0x33 in order.
//   4. Simultaneous push/pop at count=1 with y0_ready = 1.
//      -> stream 0x00..0xFF continuously to sel=0; no bubble after the first; in-order.
//      -> cnt0 wraps 0xFF -> 0x00.
//   5. clr with both FIFOs holding 2 entries and in_valid = 1.
//      -> next cycle: valids = 0, counters = 0; no byte accepted that cycle.
//   6. rst_n asserted mid-stream, between edges.
//      -> valids/data go to 0 immediately.
//      -> after release, the first accepted byte is the first output; no stale data.

Source files
------------

// File: rtl/demux8_pkg.sv
// Shared constants for the 1-to-2 byte demultiplexer.
//   SEL_Y0 / SEL_Y1 : in_sel encodings selecting output 0 / output 1
//   DEF_*           : default data width, FIFO depth and counter width
package demux8_pkg;

  localparam logic SEL_Y0 = 1'b0;
  localparam logic SEL_Y1 = 1'b1;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with pointer/count bookkeeping.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, overrides push and pop
//   push, din  : write request and data (ignored when full)
//   pop        : remove head entry (ignored when empty)
//   dout       : head entry, 0 while empty
//   empty/full : occupancy flags, derived from the count only
module sync_fifo
  import demux8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage only reads back through rd_ptr, so forcing 0 while empty keeps the
  // output clean after reset and clear without resetting the array itself.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/demux8_stream.sv
// 1-to-2 byte demultiplexer with valid/ready handshake and per-output FIFOs.
//   clk, rst_n         : clock, asynchronous active-low reset
//   clr                : synchronous clear of both FIFOs and both counters
//   in_data/sel/valid  : input byte, route select (0 -> y0, 1 -> y1), valid
//   in_ready           : accept this cycle (combinational on in_sel)
//   yX_data/valid      : head of FIFO X and its non-empty flag
//   yX_ready           : consumer X takes the head
//   cnt0, cnt1         : wrapping count of bytes accepted for each output
module demux8_stream
  import demux8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             run_q;
  logic             full0, full1, empty0, empty1;
  logic             sel_full, accept, push0, push1, pop0, pop1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Keeps in_ready low on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Only the FIFO count gates acceptance; a same-cycle pop does not free a slot.
  assign sel_full = (in_sel == SEL_Y1) ? full1 : full0;
  assign in_ready = run_q & ~clr & ~sel_full;
  assign accept   = in_valid & in_ready;
  assign push0    = accept & (in_sel == SEL_Y0);
  assign push1    = accept & (in_sel == SEL_Y1);

  assign y0_valid = ~empty0;
  assign y1_valid = ~empty1;
  assign pop0     = y0_valid & y0_ready;
  assign pop1     = y1_valid & y1_ready;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (push0) cnt0_d = cnt0_q + CNT_W'(1);
      if (push1) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .push (push0),
    .din  (in_data),
    .pop  (pop0),
    .dout (y0_data),
    .empty(empty0),
    .full (full0)
  );

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .push (push1),
    .din  (in_data),
    .pop  (pop1),
    .dout (y1_data),
    .empty(empty1),
    .full (full1)
  );

endmodule

// File: tb/tb_demux8_stream.sv
// Self-checking bench for demux8_stream: queue-based reference model compared
// on every falling edge, plus directed scenarios with literal expectations.
module tb_demux8_stream;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y0_data, y1_data;
  logic       y0_valid, y1_valid;
  logic       y0_ready = 1'b0;
  logic       y1_ready = 1'b0;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  demux8_stream #(
    .WIDTH(8),
    .DEPTH(DEPTH),
    .CNT_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .in_data (in_data),
    .in_sel  (in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y0_data (y0_data),
    .y0_valid(y0_valid),
    .y0_ready(y0_ready),
    .y1_data (y1_data),
    .y1_valid(y1_valid),
    .y1_ready(y1_ready),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_c0 = 8'h00;
  logic [7:0] m_c1 = 8'h00;
  bit         m_run = 1'b0;
  bit         m_acc, m_pop0, m_pop1;

  function automatic bit m_in_ready();
    int sz;
    sz = in_sel ? q1.size() : q0.size();
    return m_run && !clr && (sz < DEPTH);
  endfunction

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    m_c0  = 8'h00;
    m_c1  = 8'h00;
    m_run = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (clr) begin
        q0.delete();
        q1.delete();
        m_c0 = 8'h00;
        m_c1 = 8'h00;
      end else begin
        m_acc  = in_valid && m_in_ready();
        m_pop0 = y0_ready && (q0.size() > 0);
        m_pop1 = y1_ready && (q1.size() > 0);
        if (m_pop0) void'(q0.pop_front());
        if (m_pop1) void'(q1.pop_front());
        if (m_acc) begin
          if (in_sel) begin
            q1.push_back(in_data);
            m_c1 = m_c1 + 8'd1;
          end else begin
            q0.push_back(in_data);
            m_c0 = m_c0 + 8'd1;
          end
        end
      end
      m_run = 1'b1;
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    chk("y0_valid", 32'(y0_valid), 32'(q0.size() > 0));
    chk("y1_valid", 32'(y1_valid), 32'(q1.size() > 0));
    if (q0.size() > 0) chk("y0_data", 32'(y0_data), 32'(q0[0]));
    if (q1.size() > 0) chk("y1_data", 32'(y1_data), 32'(q1[0]));
    chk("cnt0", 32'(cnt0), 32'(m_c0));
    chk("cnt1", 32'(cnt1), 32'(m_c1));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input bit s, input logic [7:0] d,
                     input bit r0, input bit r1, input bit c);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    y0_ready = r0;
    y1_ready = r1;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst y0_valid", 32'(y0_valid), 32'h0);
    chk("rst y1_valid", 32'(y1_valid), 32'h0);
    chk("rst y0_data", 32'(y0_data), 32'h0);
    chk("rst y1_data", 32'(y1_data), 32'h0);
    chk("rst cnt0", 32'(cnt0), 32'h0);
    chk("rst cnt1", 32'(cnt1), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("in_ready after release", 32'(in_ready), 32'h0);
    cyc(0, 0, 8'h00, 0, 0, 0);
    chk("in_ready after first edge", 32'(in_ready), 32'h1);

    // 2. route
    cyc(1, 0, 8'hA5, 1, 1, 0);
    chk("route y0_valid", 32'(y0_valid), 32'h1);
    chk("route y0_data", 32'(y0_data), 32'hA5);
    chk("route cnt0", 32'(cnt0), 32'h1);
    cyc(1, 1, 8'h3C, 1, 1, 0);
    chk("route y1_valid", 32'(y1_valid), 32'h1);
    chk("route y1_data", 32'(y1_data), 32'h3C);
    chk("route cnt1", 32'(cnt1), 32'h1);
    chk("route y0 drained", 32'(y0_valid), 32'h0);
    cyc(0, 0, 8'h00, 1, 1, 0);

    // 3. backpressure on y0, y1 keeps flowing
    cyc(1, 0, 8'h11, 0, 1, 0);
    cyc(1, 0, 8'h22, 0, 1, 0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h33;
    #1;
    chk("bp in_ready full", 32'(in_ready), 32'h0);
    chk("bp y0_data hold", 32'(y0_data), 32'h11);
    in_sel = 1'b1; in_data = 8'h77;
    #1;
    chk("bp in_ready other", 32'(in_ready), 32'h1);
    cyc(1, 1, 8'h77, 0, 1, 0);
    chk("bp y1_data", 32'(y1_data), 32'h77);
    chk("bp y0_data still", 32'(y0_data), 32'h11);
    cyc(1, 0, 8'h33, 1, 1, 0);
    chk("bp order 2nd", 32'(y0_data), 32'h22);
    cyc(1, 0, 8'h33, 1, 1, 0);
    chk("bp order 3rd", 32'(y0_data), 32'h33);
    cyc(0, 0, 8'h00, 1, 1, 0);
    chk("bp drained", 32'(y0_valid), 32'h0);

    // 4. continuous stream, push+pop at count 1, counter wrap
    cyc(0, 0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 256; i++) begin
      cyc(1, 0, 8'(i), 1, 1, 0);
      chk("stream valid", 32'(y0_valid), 32'h1);
      chk("stream data", 32'(y0_data), 32'(i));
    end
    chk("stream cnt0 wrap", 32'(cnt0), 32'h0);
    cyc(0, 0, 8'h00, 1, 1, 0);

    // 5. clear with both FIFOs holding 2 entries
    cyc(1, 0, 8'h01, 0, 0, 0);
    cyc(1, 0, 8'h02, 0, 0, 0);
    cyc(1, 1, 8'h03, 0, 0, 0);
    cyc(1, 1, 8'h04, 0, 0, 0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h99; clr = 1'b1;
    #1;
    chk("clr in_ready", 32'(in_ready), 32'h0);
    cyc(1, 0, 8'h99, 0, 0, 1);
    chk("clr y0_valid", 32'(y0_valid), 32'h0);
    chk("clr y1_valid", 32'(y1_valid), 32'h0);
    chk("clr cnt0", 32'(cnt0), 32'h0);
    chk("clr cnt1", 32'(cnt1), 32'h0);
    cyc(0, 0, 8'h00, 0, 0, 0);

    // 6. asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) cyc(1, 1'($urandom), 8'($urandom), 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst y0_valid", 32'(y0_valid), 32'h0);
    chk("arst y1_valid", 32'(y1_valid), 32'h0);
    chk("arst y0_data", 32'(y0_data), 32'h0);
    chk("arst y1_data", 32'(y1_data), 32'h0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 8'h00, 0, 0, 0);
    cyc(1, 0, 8'hE1, 0, 1, 0);
    chk("post-rst first byte", 32'(y0_data), 32'hE1);
    cyc(0, 0, 8'h00, 1, 1, 0);
    chk("post-rst no stale", 32'(y0_valid), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
          $urandom_range(0, 63) == 0);
    end
    cyc(0, 0, 8'h00, 1, 1, 0);
    cyc(0, 0, 8'h00, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
